// File: rtl/rx_gearbox_66b_if.sv
// rx_gearbox_66b_if: RX word stream in, 66b block headers/payload out, plus slip request.
interface rx_gearbox_66b_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int HDR_WIDTH   = 2,
   parameter int BLOCK_WIDTH = 64
);
   logic [DATA_WIDTH-1:0]  i_data;
   logic                   i_data_valid;
   logic                   i_slip;
   logic [HDR_WIDTH-1:0]   o_hdr;
   logic [BLOCK_WIDTH-1:0] o_data;
   logic                   o_hdr_valid;
   logic [6:0]             o_bit_count;
   modport master (output i_data, i_data_valid, i_slip,
                   input  o_hdr, o_data, o_hdr_valid, o_bit_count);
   modport slave  (input  i_data, i_data_valid, i_slip,
                   output o_hdr, o_data, o_hdr_valid, o_bit_count);
endinterface

// File: rtl/rx_gearbox_66b.sv
// rx_gearbox_66b: packs 32b RX words into 66b blocks (hdr + payload) with single-bit slip.
module rx_gearbox_66b #(
   parameter int DATA_WIDTH  = 32,
   parameter int HDR_WIDTH   = 2,
   parameter int BLOCK_WIDTH = 64
) (
   input logic             i_clk,
   input logic             i_reset,
   rx_gearbox_66b_if.slave bus
);
   localparam int BW        = HDR_WIDTH + BLOCK_WIDTH;
   localparam int BUF_WIDTH = BW + DATA_WIDTH - 1;
   logic [BUF_WIDTH-1:0] sr, sr_app, sr_slip, sr_next;
   logic [6:0]           cnt, cnt_app, cnt_slip, cnt_next;
   logic                 pend, pend_next, do_slip, emit;
   // bits at and above cnt are always zero, so appending is a shifted OR
   always_comb begin
      sr_app    = bus.i_data_valid ? sr | (BUF_WIDTH'(bus.i_data) << cnt) : sr;
      cnt_app   = cnt + (bus.i_data_valid ? 7'(DATA_WIDTH) : 7'd0);
      do_slip   = (bus.i_slip | pend) && cnt_app != 7'd0;
      pend_next = (bus.i_slip | pend) && !do_slip;
      sr_slip   = do_slip ? sr_app >> 1 : sr_app;
      cnt_slip  = cnt_app - 7'(do_slip);
      emit      = cnt_slip >= 7'(BW);
      sr_next   = emit ? sr_slip >> BW : sr_slip;
      cnt_next  = emit ? cnt_slip - 7'(BW) : cnt_slip;
   end
   always_ff @(posedge i_clk)
      if (i_reset) begin
         sr              <= '0;
         cnt             <= '0;
         pend            <= 1'b0;
         bus.o_hdr       <= '0;
         bus.o_data      <= '0;
         bus.o_hdr_valid <= 1'b0;
      end else begin
         sr              <= sr_next;
         cnt             <= cnt_next;
         pend            <= pend_next;
         bus.o_hdr_valid <= emit;
         if (emit) begin
            bus.o_hdr  <= sr_slip[HDR_WIDTH-1:0];
            bus.o_data <= sr_slip[BW-1:HDR_WIDTH];
         end
      end
   assign bus.o_bit_count = cnt;
   a_cnt_bound: assert property (@(posedge i_clk) disable iff (i_reset) cnt < 7'(BW));
endmodule

// File: tb/tb_rx_gearbox_66b.sv
// tb_rx_gearbox_66b: directed checks of block packing, slip, bubbles and reset.
module tb_rx_gearbox_66b;
   localparam logic [63:0] D     = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] D_SH1 = 64'h8091_A2B3_C4D5_E6F7;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0;
   int failures = 0;
   int consec = 0;
   logic prev_v = 1'b0;
   logic [1:0]  hq[$];
   logic [63:0] dq[$];
   bit stream[$];
   rx_gearbox_66b_if #(.DATA_WIDTH(32)) g();
   rx_gearbox_66b dut (.i_clk(clk), .i_reset(rst), .bus(g));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
      end
   endtask
   task automatic step(input logic [31:0] d, input logic v, input logic s);
      g.i_data = d;
      g.i_data_valid = v;
      g.i_slip = s;
      @(posedge clk);
      #1;
      if (g.o_hdr_valid) begin
         if (prev_v) consec++;
         hq.push_back(g.o_hdr);
         dq.push_back(g.o_data);
      end
      prev_v = g.o_hdr_valid;
      g.i_data = '0;
      g.i_data_valid = 1'b0;
      g.i_slip = 1'b0;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      step(32'hFFFF_FFFF, 1'b1, 1'b1);
      rst = 1'b0;
      hq.delete();
      dq.delete();
   endtask
   task automatic build(input int lead);
      logic [65:0] blk;
      blk = {D, 2'b01};
      stream.delete();
      for (int i = 0; i < lead; i++) stream.push_back(1'b1);
      for (int b = 0; b < 16; b++)
         for (int j = 0; j < 66; j++) stream.push_back(blk[j]);
      while (stream.size() % 32 != 0) stream.push_back(1'b0);
   endtask
   function automatic logic [31:0] word(input int w);
      logic [31:0] r;
      for (int b = 0; b < 32; b++) r[b] = stream[32*w+b];
      return r;
   endfunction
   task automatic blocks(input string tag, input int n, input logic [1:0] h, input logic [63:0] d);
      check({tag, "_nblk"}, 64'(hq.size()), 64'(n));
      foreach (hq[i]) begin
         check($sformatf("%s_hdr%0d", tag, i), 64'(hq[i]), 64'(h));
         check($sformatf("%s_dat%0d", tag, i), dq[i], d);
      end
   endtask
   task automatic run(input int from, input int slip_word, input bit gaps);
      for (int w = from; w < stream.size() / 32; w++) begin
         if (gaps && $urandom_range(0, 1) == 1) step('0, 1'b0, 1'b0);
         step(word(w), 1'b1, w + 1 == slip_word);
      end
   endtask
   initial begin
      int first;
      g.i_data = '0;
      g.i_data_valid = 1'b0;
      g.i_slip = 1'b0;
      do_reset();
      check("rst_valid", 64'(g.o_hdr_valid), 64'd0);
      check("rst_hdr", 64'(g.o_hdr), 64'd0);
      check("rst_data", g.o_data, 64'd0);
      check("rst_cnt", 64'(g.o_bit_count), 64'd0);
      // aligned stream
      build(0);
      first = 0;
      for (int w = 0; w < 33; w++) begin
         step(word(w), 1'b1, 1'b0);
         if (first == 0 && hq.size() > 0) first = w + 1;
      end
      check("al_first", 64'(first), 64'd3);
      blocks("al", 16, 2'b01, D);
      check("al_cnt", 64'(g.o_bit_count), 64'd0);
      // five leading garbage bits removed by spaced slips
      do_reset();
      build(5);
      step(word(0), 1'b1, 1'b0);
      check("off_cnt0", 64'(g.o_bit_count), 64'd32);
      for (int s = 0; s < 5; s++) begin
         step('0, 1'b0, 1'b1);
         check($sformatf("off_slip%0d", s), 64'(g.o_bit_count), 64'(31 - s));
         for (int k = 0; k < 7; k++) step('0, 1'b0, 1'b0);
      end
      run(1, 0, 1'b0);
      blocks("off", 16, 2'b01, D);
      check("off_cnt", 64'(g.o_bit_count), 64'd27);
      // slip while empty stays pending until the first word
      do_reset();
      step('0, 1'b0, 1'b1);
      check("emp_cnt0", 64'(g.o_bit_count), 64'd0);
      build(1);
      step(word(0), 1'b1, 1'b0);
      check("emp_cnt1", 64'(g.o_bit_count), 64'd31);
      run(1, 0, 1'b0);
      blocks("emp", 16, 2'b01, D);
      check("emp_cnt", 64'(g.o_bit_count), 64'd31);
      // slip on the emitting word realigns that block
      do_reset();
      build(0);
      run(0, 3, 1'b0);
      blocks("coin", 15, 2'b10, D_SH1);
      check("coin_cnt", 64'(g.o_bit_count), 64'd65);
      // random bubbles
      do_reset();
      consec = 0;
      run(0, 0, 1'b1);
      blocks("gap", 16, 2'b01, D);
      check("gap_consec", 64'(consec), 64'd0);
      // reset mid-block, then reset with a pending slip
      do_reset();
      for (int w = 0; w < 10; w++) step(word(w), 1'b1, 1'b0);
      check("mid_cnt", 64'(g.o_bit_count), 64'd56);
      check("mid_hdr", 64'(g.o_hdr), 64'd1);
      do_reset();
      check("mid_rst_valid", 64'(g.o_hdr_valid), 64'd0);
      check("mid_rst_hdr", 64'(g.o_hdr), 64'd0);
      check("mid_rst_data", g.o_data, 64'd0);
      check("mid_rst_cnt", 64'(g.o_bit_count), 64'd0);
      step('0, 1'b0, 1'b1);
      do_reset();
      run(0, 0, 1'b0);
      blocks("post", 16, 2'b01, D);
      check("post_cnt", 64'(g.o_bit_count), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
